// File: rtl/arb_mux.sv
// N-channel arbitrating mux with fixed-select or round-robin grant and a one-slot registered output.
// Optional 16-bit transfer counter enabled by defining ARB_MUX_CNT_EN.
module arb_mux #(
   parameter int WIDTH = 8,
   parameter int N     = 3,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] d,
   input  logic [N-1:0]       d_valid,
   output logic [N-1:0]       d_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   y,
   output logic               y_valid,
   input  logic               y_ready,
   output logic [SEL_W-1:0]   y_src
`ifdef ARB_MUX_CNT_EN
   ,
   output logic [15:0]        xfer_cnt
`endif
);

   localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

   logic [WIDTH-1:0] ch [N];
   logic [WIDTH-1:0] y_reg;
   logic             y_valid_reg;
   logic [SEL_W-1:0] y_src_reg;
   logic [SEL_W-1:0] ptr_reg;

   logic             load_ok;
   logic [SEL_W-1:0] fix_cand;
   logic [SEL_W-1:0] rr_cand;
   logic             rr_found;
   logic [SEL_W:0]   rr_idx;
   logic [SEL_W-1:0] cand;
   logic             grant_ok;
   logic             xfer;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         assign ch[gi]      = d[gi*WIDTH +: WIDTH];
         assign d_ready[gi] = grant_ok && (cand == SEL_W'(gi));
      end
   endgenerate

   assign load_ok  = !y_valid_reg || y_ready;
   assign fix_cand = ({1'b0, sel} < N_EXT) ? sel : SEL_W'(N - 1);

   // Search ptr+1 .. ptr+N (mod N), so the last winner has lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_cand  = ptr_reg;
      rr_idx   = '0;
      for (int k = 1; k <= N; k++) begin
         rr_idx = {1'b0, ptr_reg} + (SEL_W + 1)'(k);
         if (rr_idx >= N_EXT) begin
            rr_idx = rr_idx - N_EXT;
         end
         if (!rr_found && d_valid[rr_idx[SEL_W-1:0]]) begin
            rr_found = 1'b1;
            rr_cand  = rr_idx[SEL_W-1:0];
         end
      end
   end

   // Fixed mode offers ready even to an idle channel; round-robin only to a requester.
   assign cand     = mode ? rr_cand : fix_cand;
   assign grant_ok = load_ok && (mode ? rr_found : 1'b1);
   assign xfer     = grant_ok && d_valid[cand];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y_reg       <= '0;
         y_valid_reg <= 1'b0;
         y_src_reg   <= '0;
         ptr_reg     <= SEL_W'(N - 1);
      end else begin
         if (xfer) begin
            y_reg       <= ch[cand];
            y_src_reg   <= cand;
            y_valid_reg <= 1'b1;
            if (mode) begin
               ptr_reg <= cand;
            end
         end else if (y_ready) begin
            y_valid_reg <= 1'b0;
         end
      end
   end

`ifdef ARB_MUX_CNT_EN
   logic [15:0] xfer_cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xfer_cnt_reg <= '0;
      end else if (xfer) begin
         xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
      end
   end

   assign xfer_cnt = xfer_cnt_reg;
`endif

   assign y       = y_reg;
   assign y_valid = y_valid_reg;
   assign y_src   = y_src_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Directed, table-driven bench for arb_mux (N=3, WIDTH=8) with hand-written stall and reset sequences.
// Defining ARB_MUX_CNT_EN also exercises the transfer counter wrap.
module tb_arb_mux;

   localparam int WIDTH = 8;
   localparam int N     = 3;
   localparam int SEL_W = 2;

   logic               clk;
   logic               reset_n;
   logic [N*WIDTH-1:0] d;
   logic [N-1:0]       d_valid;
   logic [N-1:0]       d_ready;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic [WIDTH-1:0]   y;
   logic               y_valid;
   logic               y_ready;
   logic [SEL_W-1:0]   y_src;
`ifdef ARB_MUX_CNT_EN
   logic [15:0]        xfer_cnt;
`endif

   int n_cmp;
   int n_bad;

   arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .d        (d),
      .d_valid  (d_valid),
      .d_ready  (d_ready),
      .mode     (mode),
      .sel      (sel),
      .y        (y),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y_src    (y_src)
`ifdef ARB_MUX_CNT_EN
      ,
      .xfer_cnt (xfer_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [2:0]  dv;
      logic [23:0] din;
      logic [2:0]  exp_rdy;
      logic        exp_v;
      logic [7:0]  exp_y;
      logic [1:0]  exp_src;
   } vec_t;

   vec_t tbl [16];

   initial begin
      // all vectors run with y_ready=1; ptr evolution noted per line
      tbl[0]  = '{1'b0, 2'd3, 3'b111, 24'h332211, 3'b100, 1'b1, 8'h33, 2'd2}; // sel saturates
      tbl[1]  = '{1'b0, 2'd0, 3'b000, 24'h332211, 3'b001, 1'b0, 8'h33, 2'd2}; // ready w/o valid
      tbl[2]  = '{1'b0, 2'd1, 3'b010, 24'h332211, 3'b010, 1'b1, 8'h22, 2'd1};
      tbl[3]  = '{1'b1, 2'd0, 3'b111, 24'h332211, 3'b001, 1'b1, 8'h11, 2'd0}; // ptr 2->0
      tbl[4]  = '{1'b1, 2'd0, 3'b111, 24'h332211, 3'b010, 1'b1, 8'h22, 2'd1}; // ->1
      tbl[5]  = '{1'b1, 2'd0, 3'b111, 24'h332211, 3'b100, 1'b1, 8'h33, 2'd2}; // ->2
      tbl[6]  = '{1'b1, 2'd0, 3'b111, 24'h332211, 3'b001, 1'b1, 8'h11, 2'd0}; // ->0
      tbl[7]  = '{1'b1, 2'd0, 3'b000, 24'h332211, 3'b000, 1'b0, 8'h11, 2'd0}; // idle, hold
      tbl[8]  = '{1'b1, 2'd0, 3'b010, 24'h332211, 3'b010, 1'b1, 8'h22, 2'd1}; // ->1
      tbl[9]  = '{1'b1, 2'd0, 3'b101, 24'h332211, 3'b100, 1'b1, 8'h33, 2'd2}; // ->2
      tbl[10] = '{1'b1, 2'd0, 3'b101, 24'h332211, 3'b001, 1'b1, 8'h11, 2'd0}; // ->0
      tbl[11] = '{1'b0, 2'd2, 3'b111, 24'hC35AF0, 3'b100, 1'b1, 8'hC3, 2'd2}; // ptr stays 0
      tbl[12] = '{1'b1, 2'd0, 3'b111, 24'hC35AF0, 3'b010, 1'b1, 8'h5A, 2'd1}; // ->1
      tbl[13] = '{1'b1, 2'd0, 3'b100, 24'hC35AF0, 3'b100, 1'b1, 8'hC3, 2'd2}; // ->2
      tbl[14] = '{1'b1, 2'd0, 3'b001, 24'hC35AF0, 3'b001, 1'b1, 8'hF0, 2'd0}; // ->0
      tbl[15] = '{1'b0, 2'd3, 3'b000, 24'hC35AF0, 3'b100, 1'b0, 8'hF0, 2'd0};
   end

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      d       = '0;
      d_valid = '0;
      mode    = 1'b1;
      sel     = '0;
      y_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_y_valid", 32'(y_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_y_src", 32'(y_src), 32'd0);
      chk("rst_d_ready", 32'(d_ready), 32'd0);
`ifdef ARB_MUX_CNT_EN
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         mode    = tbl[i].mode;
         sel     = tbl[i].sel;
         d_valid = tbl[i].dv;
         d       = tbl[i].din;
         y_ready = 1'b1;
         #1;
         chk($sformatf("vec%0d_d_ready", i), 32'(d_ready), 32'(tbl[i].exp_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_y_valid", i), 32'(y_valid), 32'(tbl[i].exp_v));
         chk($sformatf("vec%0d_y", i), 32'(y), 32'(tbl[i].exp_y));
         chk($sformatf("vec%0d_y_src", i), 32'(y_src), 32'(tbl[i].exp_src));
         $display("vec %0d: mode=%0d sel=%0d dv=%b -> d_ready=%b y_valid=%0d y=%h y_src=%0d",
                  i, mode, sel, d_valid, d_ready, y_valid, y, y_src);
      end

      // backpressure: load ch1, stall 4 cycles while inputs/mode/sel wiggle
      @(negedge clk);
      mode = 1'b0; sel = 2'd1; d_valid = 3'b111; d = 24'h332211; y_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_load_y", 32'(y), 32'h22);
      chk("bp_load_v", 32'(y_valid), 32'd1);
      $display("bp load: y=%h y_src=%0d y_valid=%0d", y, y_src, y_valid);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         y_ready = 1'b0;
         d       = 24'hAABBCC;
         mode    = c[0];
         sel     = 2'(c);
         #1;
         chk($sformatf("bp%0d_d_ready", c), 32'(d_ready), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_y", c), 32'(y), 32'h22);
         chk($sformatf("bp%0d_y_src", c), 32'(y_src), 32'd1);
         chk($sformatf("bp%0d_y_valid", c), 32'(y_valid), 32'd1);
         $display("bp stall %0d: y=%h y_src=%0d d_ready=%b", c, y, y_src, d_ready);
      end
      @(negedge clk);
      y_ready = 1'b1; mode = 1'b0; sel = 2'd0;
      #1;
      chk("bp_rel_d_ready", 32'(d_ready), 32'b001);
      @(posedge clk);
      #1;
      chk("bp_rel_y", 32'(y), 32'hCC);
      chk("bp_rel_y_src", 32'(y_src), 32'd0);
      chk("bp_rel_y_valid", 32'(y_valid), 32'd1);
      $display("bp release: y=%h y_src=%0d y_valid=%0d", y, y_src, y_valid);
      @(negedge clk);
      d_valid = 3'b000;
      @(posedge clk);
      #1;
      chk("drain_y_valid", 32'(y_valid), 32'd0);
      chk("drain_y_hold", 32'(y), 32'hCC);
      $display("drain: y_valid=%0d y=%h", y_valid, y);

      // async reset mid-stream; ptr is 0 here so round-robin grants ch1 first
      @(negedge clk);
      mode = 1'b1; d_valid = 3'b111; d = 24'h332211; y_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("pre_rst_y", 32'(y), 32'h22);
      chk("pre_rst_v", 32'(y_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_y_valid", 32'(y_valid), 32'd0);
      chk("async_rst_y", 32'(y), 32'd0);
      chk("async_rst_y_src", 32'(y_src), 32'd0);
`ifdef ARB_MUX_CNT_EN
      chk("async_rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
      $display("async reset: y_valid=%0d y=%h y_src=%0d", y_valid, y, y_src);
      @(posedge clk);
      #1;
      chk("rst_edge_no_xfer", 32'(y_valid), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("post_rst_d_ready", 32'(d_ready), 32'b001);
      @(posedge clk);
      #1;
      chk("post_rst_y", 32'(y), 32'h11);
      chk("post_rst_y_src", 32'(y_src), 32'd0);
      $display("post reset: y=%h y_src=%0d", y, y_src);
`ifdef ARB_MUX_CNT_EN
      chk("cnt_one", 32'(xfer_cnt), 32'd1);
      repeat (65535) @(posedge clk);
      #1;
      chk("cnt_wrap", 32'(xfer_cnt), 32'd0);
      $display("counter after 65536 transfers: %h", xfer_cnt);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width per channel in bits.
REQ-002 The block SHALL have parameter N, default 3, meaning input channel count; legal range 2..16.
REQ-003 The block SHALL have derived parameter SEL_W = max(1, clog2(N)), meaning index width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port d, input, N*WIDTH, packed channel data, where channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port d_valid, input, N, per-channel request.
REQ-008 The block SHALL have port d_ready, output, N, per-channel accept.
REQ-009 The block SHALL have port mode, input, 1, the arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port sel, input, SEL_W, the channel index used in fixed mode.
REQ-011 The block SHALL have port y, output, WIDTH, registered output data.
REQ-012 The block SHALL have port y_valid, output, 1, meaning y holds an untaken word.
REQ-013 The block SHALL have port y_ready, input, 1, downstream accept.
REQ-014 The block SHALL have port y_src, output, SEL_W, the channel index that produced the current y.

Function
REQ-015 The output stage SHALL be one register slot; load_ok = !y_valid || y_ready.
REQ-016 In fixed mode, the candidate channel SHALL be sel when sel < N, and N-1 when sel >= N (out-of-range saturates to the last channel).
REQ-017 In round-robin mode, the candidate channel SHALL be the first channel with d_valid set, searching upward from ptr+1 and wrapping modulo N; ptr is included last.
REQ-018 d_ready[i] SHALL be 1 only for the candidate channel, only when load_ok=1, and in fixed mode regardless of that channel's d_valid; all other bits SHALL be 0.
REQ-019 A transfer SHALL occur when d_valid[c] && d_ready[c]; on that edge y<=d[c], y_src<=c, y_valid<=1; latency input-to-output SHALL be exactly 1 cycle.
REQ-020 When y_valid && y_ready && no transfer occurs, y_valid SHALL clear on that edge; y and y_src SHALL hold their values.
REQ-021 Simultaneous y_ready drain and new transfer on the same edge SHALL yield y_valid=1 with the new word (full-throughput, one word per cycle).
REQ-022 When y_valid && !y_ready, y, y_src and y_valid SHALL hold, and all d_ready bits SHALL be 0.
REQ-023 The round-robin pointer ptr SHALL update to c only on a transfer in round-robin mode; fixed-mode transfers SHALL leave ptr unchanged.
REQ-024 When no channel is valid in round-robin mode, no transfer SHALL occur and ptr SHALL hold.
REQ-025 A mode or sel change SHALL take effect in the same cycle (combinational candidate) and SHALL NOT disturb a word already in y.
REQ-026 The design SHALL contain no combinational path from y_ready to y; the path from y_ready to d_ready is permitted.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force y_valid=0, y=0, y_src=0, ptr=N-1 (so channel 0 has first priority), and the counter (if present) to 0, independent of clk.
REQ-028 Reset asserted mid-transfer SHALL discard the word held in y; no transfer SHALL occur on the first edge that sees reset_n=0.
REQ-029 After reset_n deasserts, normal operation SHALL begin on the next rising edge.

Configuration
REQ-030 When macro ARB_MUX_CNT_EN is defined, the block SHALL add output xfer_cnt, 16 bits, which increments by 1 on every input transfer and wraps from 0xFFFF to 0x0000.
REQ-031 When ARB_MUX_CNT_EN is undefined, the port xfer_cnt and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Fixed mode, N=3, sel=3, d={0x33,0x22,0x11} (ch2..ch0), all valid, y_ready=1 -> d_ready=3'b100, next cycle y=0x33, y_src=2.
REQ-033 Round-robin mode, all 3 valid every cycle, y_ready=1 after reset -> y_src sequence 0,1,2,0,1,2 on consecutive cycles, one word per cycle.
REQ-034 Backpressure: y_valid=1, y_ready=0 for 4 cycles -> y stable and d_ready=0 throughout; on the cycle y_ready=1, drain and reload on the same edge.
REQ-035 Round-robin mode, only ch1 valid, then ch0 and ch2 both valid -> after the ch1 grant the next grant is ch2, then ch0.
REQ-036 Assert reset_n low between edges while y_valid=1 -> y_valid=0 immediately; with ARB_MUX_CNT_EN defined, xfer_cnt=0, and 65536 transfers after release return xfer_cnt to 0.
